// File: rtl/y86_pkg.sv
// Shared Y86-64 front-end definitions: icode values, fetch FSM states, reset PC.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'd64;

    // FETCH issues beats, PRESENT holds the window for the decoder,
    // HALT is terminal until reset, DRAIN swallows an abandoned read.
    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_PRESENT = 2'd1,
        ST_HALT    = 2'd2,
        ST_DRAIN   = 2'd3
    } fs_state_t;

endpackage

// File: rtl/y86_insn_len.sv
// Maps an icode to instruction length in bytes and an invalid-opcode flag.
// Latency: purely combinational.
// Backpressure: none.
module y86_insn_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       inv
);

    // Length table; undefined icodes are treated as 1-byte invalid opcodes.
    always_comb begin
        len = 4'd1;
        inv = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET:                len = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:    len = 4'd2;
            I_JXX, I_CALL:                       len = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:        len = 4'd10;
            default: begin
                len = 4'd1;
                inv = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, issues 2-byte imem reads and assembles a 10-byte big-endian instruction window.
// Latency: with ack tied high, 1 cycle after first request for 1/2-byte, 5 cycles for 9/10-byte.
// Backpressure: instruction held stable while instr_valid && !instr_ready; requests held until ack.
module fetch_sequencer
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_err,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [79:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [3:0]        instr_len,
    output logic              instr_inv,
    output logic              instr_mem_err,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    fs_state_t         state_q, state_nxt;
    logic [ADDR_W-1:0] pc_q, pc_nxt;
    logic [ADDR_W-1:0] tgt_q, tgt_nxt;
    logic [2:0]        beat_q, beat_nxt;
    logic [3:0]        len_q, len_nxt;
    logic              inv_q, inv_nxt;
    logic              merr_q, merr_nxt;
    logic              req_q, req_nxt;
    logic [79:0]       win_q, win_nxt;

    logic [3:0]        dec_len;
    logic              dec_inv;
    logic [3:0]        cur_len;
    logic              xfer;
    logic              accept;
    logic              halt_cond;
    logic [4:0]        off_lo;
    logic [4:0]        off_hi;
    logic [4:0]        stored;
    logic [6:0]        hi0;
    logic [6:0]        hi1;

    y86_insn_len u_insn_len (
        .icode (imem_rdata[15:12]),
        .len   (dec_len),
        .inv   (dec_inv)
    );

    // Byte offsets of the current beat; only the first beat carries the icode.
    assign xfer      = req_q && imem_ack;
    assign accept    = (state_q == ST_PRESENT) && instr_ready;
    assign halt_cond = (win_q[79:76] == I_HALT) || inv_q || merr_q;
    assign cur_len   = (beat_q == 3'd0) ? dec_len : len_q;
    assign off_lo    = {1'b0, beat_q, 1'b0};
    assign off_hi    = off_lo + 5'd1;
    assign stored    = off_lo + 5'd2;
    assign hi0       = 7'd79 - {beat_q, 4'b0000};
    assign hi1       = hi0 - 7'd8;

    // Next-state and datapath update; redirect outranks every sequential update.
    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        tgt_nxt   = tgt_q;
        beat_nxt  = beat_q;
        len_nxt   = len_q;
        inv_nxt   = inv_q;
        merr_nxt  = merr_q;
        win_nxt   = win_q;

        case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    win_nxt  = '0;
                    len_nxt  = '0;
                    inv_nxt  = 1'b0;
                    merr_nxt = 1'b0;
                    if (req_q && !imem_ack) begin
                        // Bus still owes us a beat: keep address stable and wait it out.
                        tgt_nxt   = redirect_pc;
                        state_nxt = ST_DRAIN;
                    end else begin
                        pc_nxt   = redirect_pc;
                        beat_nxt = '0;
                    end
                end else if (xfer) begin
                    if (imem_err) begin
                        merr_nxt  = 1'b1;
                        state_nxt = ST_PRESENT;
                        if (beat_q == 3'd0) begin
                            len_nxt = 4'd1;
                            inv_nxt = 1'b0;
                        end
                    end else begin
                        win_nxt[hi0 -: 8] = imem_rdata[15:8];
                        // Odd trailing byte past the instruction end stays zero.
                        if (off_hi < {1'b0, cur_len}) begin
                            win_nxt[hi1 -: 8] = imem_rdata[7:0];
                        end
                        if (beat_q == 3'd0) begin
                            len_nxt = dec_len;
                            inv_nxt = dec_inv;
                        end
                        if (stored >= {1'b0, cur_len}) begin
                            state_nxt = ST_PRESENT;
                        end else begin
                            beat_nxt = beat_q + 3'd1;
                        end
                    end
                end
            end

            ST_PRESENT: begin
                if (redirect_valid || (accept && !halt_cond)) begin
                    pc_nxt    = redirect_valid ? redirect_pc : (pc_q + ADDR_W'(len_q));
                    beat_nxt  = '0;
                    win_nxt   = '0;
                    len_nxt   = '0;
                    inv_nxt   = 1'b0;
                    merr_nxt  = 1'b0;
                    state_nxt = ST_FETCH;
                end else if (accept) begin
                    state_nxt = ST_HALT;
                end
            end

            ST_DRAIN: begin
                if (xfer) begin
                    pc_nxt    = redirect_valid ? redirect_pc : tgt_q;
                    beat_nxt  = '0;
                    state_nxt = ST_FETCH;
                end else if (redirect_valid) begin
                    tgt_nxt = redirect_pc;
                end
            end

            ST_HALT: begin
                state_nxt = ST_HALT;
            end

            default: begin
                state_nxt = ST_FETCH;
            end
        endcase

        req_nxt = (state_nxt == ST_FETCH) || (state_nxt == ST_DRAIN);
    end

    // State register; synchronous reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= ADDR_W'(RESET_PC);
            tgt_q   <= ADDR_W'(RESET_PC);
            beat_q  <= '0;
            len_q   <= '0;
            inv_q   <= 1'b0;
            merr_q  <= 1'b0;
            req_q   <= 1'b0;
            win_q   <= '0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            tgt_q   <= tgt_nxt;
            beat_q  <= beat_nxt;
            len_q   <= len_nxt;
            inv_q   <= inv_nxt;
            merr_q  <= merr_nxt;
            req_q   <= req_nxt;
            win_q   <= win_nxt;
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = pc_q + ADDR_W'({beat_q, 1'b0});
    assign instr_valid   = (state_q == ST_PRESENT);
    assign instr         = win_q;
    assign instr_pc      = pc_q;
    assign instr_len     = len_q;
    assign instr_inv     = inv_q;
    assign instr_mem_err = merr_q;
    assign halted        = (state_q == ST_HALT);

endmodule
